// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch: fetches program memory over req/ack into a DEPTH-entry FIFO and hands
// PC-tagged instructions to the core over valid/ready. `PF_STATS_EN adds fetch/drop counters.
module instr_prefetch_unit #(
  parameter int IW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic          ins_valid,
  output logic [IW-1:0] ins_data,
  output logic [AW-1:0] ins_pc,
  input  logic          ins_ready,
  input  logic          flush,
  input  logic [AW-1:0] flush_pc
`ifdef PF_STATS_EN
  ,
  output logic [7:0]    stat_fetch,
  output logic [7:0]    stat_drop
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {S_FETCH, S_DROP} state_t;

  state_t           r_state, w_state_n;
  logic [AW-1:0]    r_fetch_pc, w_fetch_pc_n;
  logic [AW-1:0]    r_mem_addr, w_mem_addr_n;
  logic             r_mem_req, w_mem_req_n;
  logic [CW-1:0]    r_count, w_count_n;
  logic [PW-1:0]    r_rd_ptr, w_rd_ptr_n;
  logic [PW-1:0]    r_wr_ptr, w_wr_ptr_n;
  logic [IW+AW-1:0] r_fifo [DEPTH];
  logic [IW+AW-1:0] w_head;
  logic             r_ins_valid;
  logic [IW-1:0]    r_ins_data;
  logic [AW-1:0]    r_ins_pc;
  logic             w_xfer, w_push, w_pop, w_drop;

  assign w_xfer    = r_mem_req & mem_ack;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign ins_valid = r_ins_valid;
  assign ins_data  = r_ins_data;
  assign ins_pc    = r_ins_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n    = r_state;
    w_fetch_pc_n = r_fetch_pc;
    w_count_n    = r_count;
    w_rd_ptr_n   = r_rd_ptr;
    w_wr_ptr_n   = r_wr_ptr;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_drop       = 1'b0;
    if (flush) begin
      // A request still waiting for its ack cannot be withdrawn; its data is thrown away in DROP.
      w_count_n    = '0;
      w_rd_ptr_n   = '0;
      w_wr_ptr_n   = '0;
      w_fetch_pc_n = flush_pc;
      w_drop       = w_xfer;
      if (r_state == S_FETCH) w_state_n = (r_mem_req && !mem_ack) ? S_DROP : S_FETCH;
      else                    w_state_n = mem_ack ? S_FETCH : S_DROP;
    end else if (r_state == S_DROP) begin
      if (mem_ack) begin
        w_drop    = 1'b1;
        w_state_n = S_FETCH;
      end
    end else begin
      w_push = w_xfer;
      w_pop  = r_ins_valid & ins_ready;
      if (w_push) begin
        w_wr_ptr_n   = r_wr_ptr + PW'(1);
        w_fetch_pc_n = r_fetch_pc + AW'(1);
      end
      if (w_pop) w_rd_ptr_n = r_rd_ptr + PW'(1);
      w_count_n = r_count + CW'(w_push) - CW'(w_pop);
    end

    w_mem_req_n  = (w_state_n == S_DROP) ? 1'b1 : (w_count_n < FULL);
    w_mem_addr_n = (w_state_n == S_DROP) ? r_mem_addr : w_fetch_pc_n;

    // The new head is the entry being written this edge when the FIFO was empty before it.
    w_head = r_fifo[w_rd_ptr_n];
    if (w_push && (w_rd_ptr_n == r_wr_ptr)) w_head = {mem_rdata, r_fetch_pc};
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {mem_rdata, r_fetch_pc};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc  <= '0;
      r_mem_addr  <= '0;
      r_mem_req   <= 1'b0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_ins_valid <= 1'b0;
      r_ins_data  <= '0;
      r_ins_pc    <= '0;
    end else begin
      r_fetch_pc  <= w_fetch_pc_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_req   <= w_mem_req_n;
      r_count     <= w_count_n;
      r_rd_ptr    <= w_rd_ptr_n;
      r_wr_ptr    <= w_wr_ptr_n;
      r_ins_valid <= (w_count_n != '0);
      if (w_count_n != '0) begin
        r_ins_data <= w_head[IW+AW-1:AW];
        r_ins_pc   <= w_head[AW-1:0];
      end
    end
  end

`ifdef PF_STATS_EN
  logic [7:0] r_stat_fetch, r_stat_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_fetch <= '0;
      r_stat_drop  <= '0;
    end else begin
      r_stat_fetch <= r_stat_fetch + 8'(w_push);
      r_stat_drop  <= r_stat_drop + 8'(w_drop);
    end
  end

  assign stat_fetch = r_stat_fetch;
  assign stat_drop  = r_stat_drop;
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: queue-based reference model plus a pop-side scoreboard monitor.
module tb_instr_prefetch_unit;
  localparam int IW = 8, AW = 4, DEPTH = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          mem_req, mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_rdata = '0;
  logic          ins_valid, ins_ready = 1'b0;
  logic [IW-1:0] ins_data;
  logic [AW-1:0] ins_pc;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_pc = '0;
`ifdef PF_STATS_EN
  logic [7:0]    stat_fetch, stat_drop;
`endif

  instr_prefetch_unit #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc), .ins_ready(ins_ready),
    .flush(flush), .flush_pc(flush_pc)
`ifdef PF_STATS_EN
    , .stat_fetch(stat_fetch), .stat_drop(stat_drop)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int ack_mode = 0;  // 0: always ack, 1: random ack, 2: ack after 3 wait cycles
  int wait_cnt = 0;
  logic [IW-1:0] mem_img [16];

  logic [IW+AW-1:0] exp_q[$];
  logic [AW-1:0]    popped_pc[$];
  int               m_cnt = 0;
  logic [AW-1:0]    m_pc = '0, m_drop_addr = '0;
  logic             m_drop_pend = 1'b0, m_first = 1'b1;
  logic [7:0]       m_fetch = '0, m_drops = '0;
  logic [IW+AW-1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    popped_pc.delete();
    rst = 1'b1;
  endtask

  // Memory: returns mem_img[mem_addr]; ack timing chosen by ack_mode.
  always @(posedge clk) begin
    #1;
    mem_rdata = mem_img[mem_addr];
    if (!rst || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else begin
      case (ack_mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = ($urandom_range(0, 2) == 0);
        default: mem_ack = (wait_cnt >= 3);
      endcase
      if (mem_ack) wait_cnt = 0;
      else         wait_cnt++;
    end
  end

  // Reference model: predicts handshake-level outputs and pushes expected instructions.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_ins_valid", 32'(ins_valid), 32'd0);
      chk("rst_ins_data", 32'(ins_data), 32'd0);
      chk("rst_ins_pc", 32'(ins_pc), 32'd0);
`ifdef PF_STATS_EN
      chk("rst_stat_fetch", 32'(stat_fetch), 32'd0);
      chk("rst_stat_drop", 32'(stat_drop), 32'd0);
`endif
      exp_q.delete();
      m_cnt = 0; m_pc = '0; m_drop_pend = 1'b0; m_first = 1'b1; m_fetch = '0; m_drops = '0;
    end else begin
      chk("mem_req", 32'(mem_req),
          m_first ? 32'd0 : 32'(m_drop_pend || (m_cnt < DEPTH)));
      if (mem_req) chk("mem_addr", 32'(mem_addr), 32'(m_drop_pend ? m_drop_addr : m_pc));
      chk("ins_valid", 32'(ins_valid), 32'(m_cnt != 0));
`ifdef PF_STATS_EN
      chk("stat_fetch", 32'(stat_fetch), 32'(m_fetch));
      chk("stat_drop", 32'(stat_drop), 32'(m_drops));
`endif
      m_first = 1'b0;
      if (flush) begin
        if (mem_req && mem_ack) begin
          m_drops++;
          m_drop_pend = 1'b0;
        end else if (mem_req) begin
          if (!m_drop_pend) m_drop_addr = m_pc;
          m_drop_pend = 1'b1;
        end
        exp_q.delete();
        m_cnt = 0;
        m_pc  = flush_pc;
      end else if (m_drop_pend) begin
        if (mem_ack) begin
          m_drops++;
          m_drop_pend = 1'b0;
        end
      end else begin
        if (ins_valid && ins_ready) m_cnt--;
        if (mem_req && mem_ack) begin
          exp_q.push_back({mem_img[m_pc], m_pc});
          m_cnt++;
          m_pc++;
          m_fetch++;
        end
      end
    end
  end

  // Scoreboard monitor: every consumed instruction must match the oldest prediction.
  always @(negedge clk) begin
    if (rst && ins_valid && ins_ready && !flush) begin
      if (exp_q.size() == 0) begin
        tmo("pop_without_expected");
      end else begin
        mon_e = exp_q.pop_front();
        chk("ins_data", 32'(ins_data), 32'(mon_e[IW+AW-1:AW]));
        chk("ins_pc", 32'(ins_pc), 32'(mon_e[AW-1:0]));
        popped_pc.push_back(ins_pc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_img[i] = IW'($urandom);

    // Streaming with always-ack and always-ready.
    ack_mode = 0; ins_ready = 1'b1;
    do_reset();
    repeat (20) tick();
    chk("stream_count_ge17", 32'(popped_pc.size() >= 17), 32'd1);
    for (int i = 0; i < 8; i++) chk("stream_pc", 32'(popped_pc[i]), 32'(i));

    // Fill to full with the core stalled, then release a single pop.
    ins_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    chk("full_req_low", 32'(mem_req), 32'd0);
    chk("full_no_pops", 32'(popped_pc.size()), 32'd0);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    chk("refill_req", 32'(mem_req), 32'd1);
    chk("refill_addr", 32'(mem_addr), 32'd4);
    chk("refill_pop_pc", 32'(popped_pc[0]), 32'd0);
    repeat (3) tick();

    // Flush while a slow request to address 2 is outstanding.
    ack_mode = 2; ins_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 60 && !(mem_req && mem_addr == 4'd2); i++) tick();
    if (!(mem_req && mem_addr == 4'd2)) tmo("drop_wait_addr2");
    flush = 1'b1; flush_pc = 4'd9;
    popped_pc.delete();
    tick();
    flush = 1'b0;
    chk("drop_hold_req", 32'(mem_req), 32'd1);
    chk("drop_hold_addr", 32'(mem_addr), 32'd2);
    for (int i = 0; i < 20 && mem_addr == 4'd2; i++) tick();
    chk("drop_next_addr", 32'(mem_addr), 32'd9);
    for (int i = 0; i < 40 && popped_pc.size() == 0; i++) tick();
    if (popped_pc.size() == 0) tmo("drop_wait_pop");
    else chk("drop_first_pc", 32'(popped_pc[0]), 32'd9);

    // Flush coinciding with an ack while three entries are buffered.
    ack_mode = 0; ins_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !(mem_req && mem_addr == 4'd3); i++) tick();
    if (!(mem_req && mem_addr == 4'd3)) tmo("flushack_wait");
    flush = 1'b1; flush_pc = 4'd5;
    tick();
    flush = 1'b0;
    chk("flushack_valid_low", 32'(ins_valid), 32'd0);
    popped_pc.delete();
    ins_ready = 1'b1;
    for (int i = 0; i < 20 && popped_pc.size() < 3; i++) tick();
    if (popped_pc.size() < 3) tmo("flushack_wait_pops");
    else for (int i = 0; i < 3; i++) chk("flushack_pc", 32'(popped_pc[i]), 32'(5 + i));

    // PC wrap-around.
    ack_mode = 0; ins_ready = 1'b1;
    do_reset();
    repeat (3) tick();
    flush = 1'b1; flush_pc = 4'd14;
    tick();
    flush = 1'b0;
    popped_pc.delete();
    for (int i = 0; i < 20 && popped_pc.size() < 4; i++) tick();
    if (popped_pc.size() < 4) tmo("wrap_wait_pops");
    else begin
      chk("wrap_pc0", 32'(popped_pc[0]), 32'd14);
      chk("wrap_pc1", 32'(popped_pc[1]), 32'd15);
      chk("wrap_pc2", 32'(popped_pc[2]), 32'd0);
      chk("wrap_pc3", 32'(popped_pc[3]), 32'd1);
    end

    // Random traffic: random ack, ready and flushes, then with slow memory.
    for (int ph = 1; ph <= 2; ph++) begin
      ack_mode = ph;
      do_reset();
      for (int i = 0; i < (ph == 1 ? 1500 : 400); i++) begin
        ins_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 24) == 0);
        flush_pc  = AW'($urandom);
        tick();
      end
      flush = 1'b0;
      repeat (5) tick();
    end

`ifdef PF_STATS_EN
    // Two DROP discards, then run until 20 pushes, then reset mid-burst.
    ack_mode = 2; ins_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20 && !(mem_req && !mem_ack); i++) tick();
      flush = 1'b1; flush_pc = AW'($urandom);
      tick();
      flush = 1'b0;
      for (int i = 0; i < 20 && !mem_ack; i++) tick();
      tick();
    end
    chk("stats_drop2", 32'(stat_drop), 32'd2);
    ack_mode = 0;
    for (int i = 0; i < 100 && stat_fetch != 8'd20; i++) tick();
    chk("stats_fetch20", 32'(stat_fetch), 32'd20);
    chk("stats_drop_still2", 32'(stat_drop), 32'd2);
    rst = 1'b0;
    #1;
    chk("stats_rst_fetch", 32'(stat_fetch), 32'd0);
    chk("stats_rst_drop", 32'(stat_drop), 32'd0);
    chk("stats_rst_req", 32'(mem_req), 32'd0);
    tick();
    rst = 1'b1;
    repeat (5) tick();
`endif

    ins_ready = 1'b1;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
